// File: rtl/timer32_core.sv
// 32-bit prescaled periodic timer with sticky overflow flag.
// Optional one-shot mode is built in when TIMER32_ONESHOT_EN is defined.
module timer32_core (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        TMREN,
    input  logic [31:0] PRE,
    input  logic [31:0] TMRCMP,
    input  logic        TMROVCLR,
`ifdef TIMER32_ONESHOT_EN
    input  logic        ONESHOT,
`endif
    output logic [31:0] TMR,
    output logic        TMROV
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   pcnt;
    logic [CNT_W-1:0]   pcnt_nxt;
    logic [CNT_W-1:0]   tmr_nxt;
    logic               tmrov_nxt;

    logic               oneshot_c;
    logic               count_en_c;
    logic               tick_c;
    logic               match_c;

`ifdef TIMER32_ONESHOT_EN
    assign oneshot_c = ONESHOT;
`else
    assign oneshot_c = 1'b0;
`endif

    // Counting happens on the enabling edge itself, so IDLE counts like RUN.
    assign count_en_c = TMREN && (state != ST_DONE);
    assign tick_c     = count_en_c && (pcnt == PRE);
    assign match_c    = tick_c && (TMR == TMRCMP);

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE is only entered from a one-shot match.
    always_comb begin
        state_nxt = state;
        if (!TMREN) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE,
                ST_RUN:  state_nxt = (match_c && oneshot_c) ? ST_DONE : ST_RUN;
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next values for prescaler, counter and overflow flag.
    always_comb begin
        pcnt_nxt  = pcnt;
        tmr_nxt   = TMR;
        tmrov_nxt = TMROV;
        if (!TMREN) begin
            pcnt_nxt = '0;
            tmr_nxt  = '0;
        end else if (count_en_c) begin
            pcnt_nxt = tick_c ? '0 : pcnt + CNT_W'(1);
            if (tick_c) begin
                tmr_nxt = match_c ? '0 : TMR + CNT_W'(1);
            end
        end
        if (match_c) begin
            tmrov_nxt = 1'b1;
        end
        // Clear beats a simultaneous match.
        if (TMROVCLR) begin
            tmrov_nxt = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pcnt  <= '0;
            TMR   <= '0;
            TMROV <= 1'b0;
        end else begin
            pcnt  <= pcnt_nxt;
            TMR   <= tmr_nxt;
            TMROV <= tmrov_nxt;
        end
    end

endmodule

// File: tb/tb_timer32_core.sv
// Self-checking bench for timer32_core: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_timer32_core;

    logic        PCLK;
    logic        PRESETn;
    logic        TMREN;
    logic [31:0] PRE;
    logic [31:0] TMRCMP;
    logic        TMROVCLR;
    logic        ONESHOT;
    logic [31:0] TMR;
    logic        TMROV;

    int checks;
    int failures;

    // Reference model state
    logic [31:0] m_pcnt;
    logic [31:0] m_tmr;
    logic        m_ov;
    logic        m_done;

    timer32_core dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .TMREN    (TMREN),
        .PRE      (PRE),
        .TMRCMP   (TMRCMP),
        .TMROVCLR (TMROVCLR),
`ifdef TIMER32_ONESHOT_EN
        .ONESHOT  (ONESHOT),
`endif
        .TMR      (TMR),
        .TMROV    (TMROV)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic model_reset();
        m_pcnt = 0;
        m_tmr  = 0;
        m_ov   = 1'b0;
        m_done = 1'b0;
    endtask

    // One rising edge of the timer, described from its rules.
    task automatic model_edge();
        logic tick;
        logic match;
        tick  = 1'b0;
        match = 1'b0;
        if (!TMREN) begin
            m_pcnt = 0;
            m_tmr  = 0;
            m_done = 1'b0;
        end else if (!m_done) begin
            tick = (m_pcnt == PRE);
            if (tick) m_pcnt = 0;
            else      m_pcnt = m_pcnt + 1;
            if (tick) begin
                if (m_tmr == TMRCMP) begin
                    match = 1'b1;
                    m_tmr = 0;
                end else begin
                    m_tmr = m_tmr + 1;
                end
            end
            if (match && ONESHOT) m_done = 1'b1;
        end
        if (match)    m_ov = 1'b1;
        if (TMROVCLR) m_ov = 1'b0;
    endtask

    task automatic step();
        @(posedge PCLK);
        model_edge();
        #1;
    endtask

    task automatic idle_clear();
        TMREN    = 1'b0;
        TMROVCLR = 1'b1;
        step();
        TMROVCLR = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn  = 1'b0;
        TMREN    = 1'b0;
        PRE      = 0;
        TMRCMP   = 0;
        TMROVCLR = 1'b0;
        ONESHOT  = 1'b0;
        model_reset();
        #23;
        checks++;
        if (TMR !== 32'd0 || TMROV !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: TMR=%0d TMROV=%b required 0/0", TMR, TMROV);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        step();

        // Get TMROV set, then count up to 1234 and reset asynchronously.
        PRE    = 0;
        TMRCMP = 0;
        TMREN  = 1'b1;
        step();
        TMRCMP = 32'hFFFF_FFFF;
        repeat (1234) step();
        checks++;
        if (TMR !== 32'd1234 || TMROV !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_count: TMR=%0d TMROV=%b required 1234/1", TMR, TMROV);
        end
        #2;
        PRESETn = 1'b0;
        #1;
        checks++;
        if (TMR !== 32'd0 || TMROV !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: TMR=%0d TMROV=%b required 0/0", TMR, TMROV);
        end
        model_reset();
        #1;
        PRESETn = 1'b1;
        step();
        checks++;
        if (TMR !== 32'd1) begin
            failures++;
            $display("FAIL restart_after_reset: TMR=%0d required 1", TMR);
        end
    endtask

    task automatic test_pre0();
        int exp_tmr [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        idle_clear();
        PRE    = 0;
        TMRCMP = 4;
        TMREN  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (TMR !== 32'(exp_tmr[i]) || TMROV !== (i >= 4)) begin
                failures++;
                $display("FAIL pre0_edge%0d: TMR=%0d TMROV=%b required %0d/%b",
                         i + 1, TMR, TMROV, exp_tmr[i], (i >= 4));
            end
        end
    endtask

    task automatic test_pre3();
        int exp_tmr [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
        idle_clear();
        PRE    = 3;
        TMRCMP = 1;
        TMREN  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (TMR !== 32'(exp_tmr[i]) || TMROV !== (i == 7)) begin
                failures++;
                $display("FAIL pre3_edge%0d: TMR=%0d TMROV=%b required %0d/%b",
                         i + 1, TMR, TMROV, exp_tmr[i], (i == 7));
            end
        end
    endtask

    task automatic test_ovclr();
        idle_clear();
        PRE    = 0;
        TMRCMP = 2;
        TMREN  = 1'b1;
        repeat (3) step();
        checks++;
        if (TMROV !== 1'b1) begin
            failures++;
            $display("FAIL ovclr_first_match: TMROV=%b required 1", TMROV);
        end
        repeat (2) step();
        TMROVCLR = 1'b1;
        step();
        TMROVCLR = 1'b0;
        checks++;
        if (TMROV !== 1'b0 || TMR !== 32'd0) begin
            failures++;
            $display("FAIL ovclr_wins: TMR=%0d TMROV=%b required 0/0", TMR, TMROV);
        end
        repeat (2) step();
        checks++;
        if (TMROV !== 1'b0) begin
            failures++;
            $display("FAIL ovclr_stays_clear: TMROV=%b required 0", TMROV);
        end
        step();
        checks++;
        if (TMROV !== 1'b1) begin
            failures++;
            $display("FAIL ovclr_next_match: TMROV=%b required 1", TMROV);
        end
    endtask

    task automatic test_cmp_below();
        int bad;
        idle_clear();
        PRE    = 0;
        TMRCMP = 100;
        TMREN  = 1'b1;
        repeat (10) step();
        TMRCMP = 5;
        bad = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (TMR !== 32'(10 + i) || TMROV !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL cmp_below_no_match: bad_edges=%0d required 0 (TMR=%0d TMROV=%b)",
                     bad, TMR, TMROV);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        idle_clear();
        PRE    = 32'($urandom_range(0, 3));
        TMRCMP = 32'($urandom_range(0, 6));
        TMREN  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            checks++;
            if (TMR !== m_tmr || TMROV !== m_ov) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle%0d: TMR=%0d TMROV=%b required %0d/%b",
                             i, TMR, TMROV, m_tmr, m_ov);
            end
            // Lowering PRE/TMRCMP only while disabled keeps runs out of the 2^32 wrap.
            if ($urandom_range(0, 99) < 8) begin
                TMREN  = 1'b0;
                PRE    = 32'($urandom_range(0, 3));
                TMRCMP = 32'($urandom_range(0, 6));
            end else begin
                TMREN = 1'b1;
                if ($urandom_range(0, 99) < 3) PRE = PRE + 1;
                if ($urandom_range(0, 99) < 3) TMRCMP = TMRCMP + 1;
            end
            TMROVCLR = ($urandom_range(0, 99) < 5);
`ifdef TIMER32_ONESHOT_EN
            ONESHOT = ($urandom_range(0, 3) == 0);
`endif
        end
        TMROVCLR = 1'b0;
        ONESHOT  = 1'b0;
    endtask

`ifdef TIMER32_ONESHOT_EN
    task automatic test_oneshot();
        int exp_tmr [6] = '{1, 2, 0, 0, 0, 0};
        idle_clear();
        ONESHOT = 1'b1;
        PRE     = 0;
        TMRCMP  = 2;
        TMREN   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (TMR !== 32'(exp_tmr[i]) || TMROV !== (i >= 2)) begin
                failures++;
                $display("FAIL oneshot_edge%0d: TMR=%0d TMROV=%b required %0d/%b",
                         i + 1, TMR, TMROV, exp_tmr[i], (i >= 2));
            end
        end
        TMREN = 1'b0;
        step();
        TMREN = 1'b1;
        step();
        checks++;
        if (TMR !== 32'd1) begin
            failures++;
            $display("FAIL oneshot_rearm: TMR=%0d required 1", TMR);
        end
        ONESHOT = 1'b0;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pre0();
        test_pre3();
        test_ovclr();
        test_cmp_below();
`ifdef TIMER32_ONESHOT_EN
        test_oneshot();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
